// File: rtl/waveform_gen.sv
// -----------------------------------------------------------------------------
// waveform_gen
//   Sample generator for the audio path. A 16-bit phase accumulator advances by
//   `step` on every sample strobe. The selected waveform (OFF, SQUARE, SAW, TRI)
//   is derived from the upper phase byte and registered as an unsigned 8-bit
//   sample. Each accepted strobe produces a one-cycle sample_valid pulse.
//
// Ports
//   clk           in   1   system clock, rising edge
//   n_rst         in   1   asynchronous active-low reset
//   mode          in   2   0 OFF, 1 SQUARE, 2 SAW, 3 TRI (sampled every cycle)
//   en            in   1   sample strobe, one accumulator step per high cycle
//   step          in  16   phase increment per strobe
//   sample        out  8   registered sample
//   sample_valid  out  1   pulse the cycle after each accepted en
//
// Build option
//   WAVE_GEN_PHASE_SYNC_EN : when defined, any mode change clears the phase
//   before the step is applied, so every new waveform starts at phase 0.
// -----------------------------------------------------------------------------
module waveform_gen (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  mode,
    input  logic        en,
    input  logic [15:0] step,
    output logic [7:0]  sample,
    output logic        sample_valid
);

    typedef enum logic [1:0] {
        WAVE_OFF    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_e;

    logic [15:0] phase_q, phase_d;
    logic [7:0]  sample_q, sample_d;
    logic        valid_q, valid_d;
    logic [15:0] phase_base;
    wave_e       mode_w;

    assign mode_w = wave_e'(mode);

    // Only the upper phase byte shapes the output; the low byte is fractional
    // pitch resolution.
    function automatic logic [7:0] wave_of(input wave_e m, input logic [7:0] ph);
        logic [7:0] w;
        w = 8'h00;
        case (m)
            WAVE_SQUARE: w = ph[7] ? 8'hFF : 8'h00;
            WAVE_SAW:    w = ph;
            // Ramp up over the first half, mirrored ramp down over the second.
            WAVE_TRI:    w = ph[7] ? ~{ph[6:0], 1'b0} : {ph[6:0], 1'b0};
            default:     w = 8'h00;
        endcase
        return w;
    endfunction

`ifdef WAVE_GEN_PHASE_SYNC_EN
    // Previous-cycle mode; only needed to detect a mode change for phase sync.
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) mode_q <= WAVE_OFF;
        else        mode_q <= mode;
    end

    assign phase_base = (mode != mode_q) ? 16'h0000 : phase_q;
`else
    assign phase_base = phase_q;
`endif

    always_comb begin
        phase_d  = phase_q;
        sample_d = sample_q;
        valid_d  = en;
        if (mode_w == WAVE_OFF) begin
            // OFF parks the accumulator at 0 even without a strobe.
            phase_d = 16'h0000;
            if (en) sample_d = 8'h00;
        end else if (en) begin
            phase_d  = phase_base + step;   // natural 16-bit wrap
            sample_d = wave_of(mode_w, phase_d[15:8]);
        end else begin
            phase_d = phase_base;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q  <= 16'h0000;
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_waveform_gen.sv
// -----------------------------------------------------------------------------
// tb_waveform_gen
//   Self-checking bench for waveform_gen. A behavioural model tracks the phase
//   as an integer and computes each waveform arithmetically; directed sequences
//   also compare against literal sample values.
// -----------------------------------------------------------------------------
module tb_waveform_gen;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  mode;
    logic        en;
    logic [15:0] step;
    logic [7:0]  sample;
    logic        sample_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int m_phase, m_modeq, m_sample, m_valid;

    waveform_gen dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .mode         (mode),
        .en           (en),
        .step         (step),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wave(input int m, input int p);
        case (m)
            1:       return (p >= 32768) ? 255 : 0;
            2:       return p / 256;
            3:       return (p < 32768) ? (p / 256) * 2 : 255 - ((p - 32768) / 256) * 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sample = 0; m_valid = 0; m_modeq = 0;
    endtask

    task automatic model_step();
        int base;
        base = m_phase;
`ifdef WAVE_GEN_PHASE_SYNC_EN
        if (int'(mode) != m_modeq) base = 0;
`endif
        if (mode == 2'd0) begin
            m_phase = 0;
            if (en) m_sample = 0;
        end else if (en) begin
            m_phase  = (base + int'(step)) % 65536;
            m_sample = wave(int'(mode), m_phase);
        end else begin
            m_phase = base;
        end
        m_valid = int'(en);
        m_modeq = int'(mode);
    endtask

    // One clock: apply inputs, advance the model, check just after the edge.
    task automatic cyc(input logic [1:0] m, input logic e, input logic [15:0] s, input string tag);
        mode = m; en = e; step = s;
        model_step();
        @(posedge clk);
        #1;
        chk({tag, " sample"}, sample, m_sample);
        chk({tag, " valid"}, sample_valid, m_valid);
    endtask

    logic [7:0] sq_exp [4];
    logic [7:0] tri_exp [4];

    initial begin
        sq_exp  = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        tri_exp = '{8'h80, 8'hFF, 8'h7F, 8'h00};

        // Reset held with SAW and en active: outputs must stay at reset values.
        n_rst = 1'b0; mode = 2'd2; en = 1'b1; step = 16'h0100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset sample", sample, 8'h00);
        chk("reset valid", sample_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(2'd2, 1'b1, 16'h0100, "first");
        chk("first const", sample, 8'h01);
        cyc(2'd2, 1'b0, 16'h0100, "first gap");
        chk("first pulse", sample_valid, 1'b0);

        // SAW wrap over 256 strobes
        cyc(2'd0, 1'b0, 16'h0000, "park");
        for (int i = 0; i < 256; i++) cyc(2'd2, 1'b1, 16'h0100, "saw");
        chk("saw wrap const", sample, 8'h00);

        // SQUARE
        cyc(2'd0, 1'b0, 16'h0000, "park");
        for (int i = 0; i < 4; i++) begin
            cyc(2'd1, 1'b1, 16'h4000, "square");
            chk("square const", sample, sq_exp[i]);
        end

        // TRI
        cyc(2'd0, 1'b0, 16'h0000, "park");
        for (int i = 0; i < 4; i++) begin
            cyc(2'd3, 1'b1, 16'h4000, "tri");
            chk("tri const", sample, tri_exp[i]);
        end

        // OFF and gaps
        cyc(2'd0, 1'b0, 16'h0000, "park");
        for (int i = 0; i < 3; i++) cyc(2'd2, 1'b1, 16'h1000, "gap run");
        chk("gap run const", sample, 8'h30);
        for (int i = 0; i < 5; i++) begin
            cyc(2'd2, 1'b0, 16'h1000, "gap hold");
            chk("gap hold const", sample, 8'h30);
        end
        cyc(2'd0, 1'b1, 16'h1000, "off en");
        chk("off en const", sample, 8'h00);
        chk("off en valid const", sample_valid, 1'b1);
        cyc(2'd2, 1'b1, 16'h1000, "off resume");
        chk("off resume const", sample, 8'h10);

        // Mode switch SAW -> SQUARE
        cyc(2'd0, 1'b0, 16'h0000, "park");
        for (int i = 0; i < 2; i++) cyc(2'd2, 1'b1, 16'h2000, "sw saw");
        chk("sw saw const", sample, 8'h40);
        cyc(2'd1, 1'b1, 16'h2000, "sw sq1");
        chk("sw sq1 const", sample, 8'h00);
        cyc(2'd1, 1'b1, 16'h2000, "sw sq2");
`ifdef WAVE_GEN_PHASE_SYNC_EN
        chk("sw sq2 const", sample, 8'h00);
`else
        chk("sw sq2 const", sample, 8'hFF);
`endif

        // step = 0: frozen phase, valid still pulses
        cyc(2'd2, 1'b1, 16'h0000, "step0 a");
        cyc(2'd2, 1'b1, 16'h0000, "step0 b");
        chk("step0 valid const", sample_valid, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] s;
            s = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'h0300)) : 16'($urandom);
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), s, "rand");
        end

        // Mid-stream asynchronous reset
        for (int i = 0; i < 3; i++) cyc(2'd2, 1'b1, 16'h3300, "pre rst");
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("async rst sample", sample, 8'h00);
        chk("async rst valid", sample_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(2'd2, 1'b0, 16'h0100, "post rst idle");
        chk("post rst idle const", sample, 8'h00);
        cyc(2'd2, 1'b1, 16'h0100, "post rst en");
        chk("post rst en const", sample, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/waveform_gen.md
# waveform_gen

Sample generator that consumes the 2-bit wave-mode code from the mode-select state machine and produces an unsigned 8-bit audio sample stream. A 16-bit phase accumulator advances by a programmable step on each sample strobe, and the selected waveform (OFF, SQUARE, SAW, TRI) is derived from the phase. Output feeds the downstream PWM/DAC stage with a one-cycle valid pulse per sample.

## Interface
- Parameters: none (phase width fixed at 16, sample width fixed at 8).
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset; asynchronous, active-low.
- mode  input  2  wave select: 0 OFF, 1 SQUARE, 2 SAW, 3 TRI; sampled every cycle.
- en  input  1  sample strobe; one accumulator step per cycle high.
- step  input  16  phase increment per strobe (pitch); sampled in the cycle en is high.
- sample  output  8  current sample, unsigned, registered.
- sample_valid  output  1  single-cycle pulse, high the cycle after each accepted en.

## Operation
- State: phase[15:0], sample[7:0], sample_valid, mode_q[1:0] (previous mode).
- Reset: phase=0, sample=8'h00, sample_valid=0, mode_q=OFF.
- Cycle with en=1 and mode!=OFF: phase_next = phase + step, modulo 2^16 (carry discarded, natural wrap).
- Cycle with mode==OFF: phase_next = 0 regardless of en; sample register loads 8'h00 when en=1.
- Cycle with en=0: phase and sample hold; sample_valid=0.
- Waveform from phase_next (p):
  - SQUARE: p[15] ? 8'hFF : 8'h00.
  - SAW: p[15:8].
  - TRI: p[15] ? ~{p[14:8],1'b0} : {p[14:8],1'b0}.
  - OFF: 8'h00.
- Mode change between non-OFF modes: phase continues uninterrupted (unless the configured feature below is compiled in); the new waveform applies to the first sample computed in the cycle mode changes.
- sample_valid asserts on every en=1 cycle, including OFF mode.
- step=0: phase frozen, sample constant, sample_valid still pulses.
- mode_q updates every cycle to mode.

## Timing
- Latency: en high in cycle t -> sample and sample_valid updated at the rising edge ending cycle t; visible throughout cycle t+1.
- Back-to-back en: one sample per cycle; no throughput limit.
- n_rst asserted mid-stream: all outputs return to reset values immediately (asynchronously); first sample after release requires a fresh en.
- No combinational path from inputs to outputs.

## Configuration
- WAVE_GEN_PHASE_SYNC_EN defined: any cycle where mode != mode_q, phase is cleared to 0 before the step is applied (phase_next = step if en, else 0); each new waveform starts at phase 0.
- Undefined: phase is cleared only in OFF; switching between SQUARE/SAW/TRI keeps the running phase.

## Test plan
- Reset: n_rst low with mode=SAW, en=1 -> sample=8'h00, sample_valid=0, phase=0; release, one en with step=16'h0100 -> sample=8'h01, sample_valid=1 for one cycle.
- SAW wrap: mode=SAW, step=16'h0100, 256 consecutive en -> samples 01,02,…,FF,00; last sample 8'h00 (wrap).
- SQUARE: mode=SQUARE, step=16'h4000, 4 en -> samples 00,FF,FF,00.
- TRI: mode=TRI, step=16'h4000, 4 en -> samples 80,FF,7F,00.
- OFF and gaps: mode=SAW step=16'h1000, 3 en (sample 30), en low 5 cycles -> sample holds 30, valid 0; switch mode=OFF, 1 en -> sample 00, valid 1; back to SAW, 1 en -> sample 10.
- Mode switch: SAW step=16'h2000, 2 en (sample 40), switch to SQUARE, 1 en -> without macro sample 00 (phase 6000); with WAVE_GEN_PHASE_SYNC_EN sample 00 and phase=16'h2000, next en -> 00 vs (without) 8'hFF.
